// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants and state type for the bit-serial adder
package adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_HOLD  = ST_HOLD
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// rtl/serial_adder_ctrl_if.sv - operand and result handshakes of the serial adder
interface serial_adder_ctrl_if
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, op_a, op_b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, op_a, op_b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - single-bit combinational full adder
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial add/subtract sequencer, one bit per clock LSB first
module serial_adder_ctrl
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_adder_ctrl_if.slave bus
);
    localparam int            CW         = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_MSB_IN = CW'(WIDTH - 2);
    localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);

    state_t           state;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             carry_msb_in;
    logic             cout_q;
    logic             ovf_q;
    logic [CW-1:0]    cnt;
    logic             s_bit;
    logic             c_bit;

    full_adder_cell u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry),
        .sum  (s_bit),
        .cout (c_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            sum_q        <= '0;
            carry        <= 1'b0;
            carry_msb_in <= 1'b0;
            cout_q       <= 1'b0;
            ovf_q        <= 1'b0;
            cnt          <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        // Subtraction is A + ~B + 1, so invert B and force the carry in here.
                        a_q        <= bus.op_a;
                        b_q        <= bus.sub ? ~bus.op_b : bus.op_b;
                        carry      <= bus.sub ? 1'b1 : bus.cin;
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    sum_q <= {s_bit, sum_q[WIDTH-1:1]};
                    carry <= c_bit;
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_MSB_IN) begin
                        carry_msb_in <= c_bit;
                    end
                    if (cnt == CNT_LAST) begin
                        cout_q      <= c_bit;
                        ovf_q       <= carry_msb_in ^ c_bit;
                        out_valid_q <= 1'b1;
                        state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule
